// File: rtl/synth_slot_sequencer.sv
// Purpose : sequence the voice x oscillator time-multiplexed datapath from the
//           divided slot clock and the sample-frame clock. It emits one strobe
//           per slot with that slot's indices, plus a frame-start strobe, and
//           detects and counts frame/slot slips.
// Latency : 3 OSC_CLK edges from a rise captured at sync flop 1 to the
//           corresponding registered strobe.
// Backpressure: none. The strobes are pulses that cannot be stalled, and
//           iENABLE low drops the sequencer back to waiting for a frame.
// Ports   : OSC_CLK/iRST_N clock and async active-low reset; iENABLE run enable;
//           iSLOT_CLK/iFRAME_CLK async slot and frame clocks; iCLR_SLIP clears
//           the slip counter; oVOICE_IDX/oOSC_IDX slot indices; oSLOT_STB and
//           oFRAME_STB strobes; oLOCKED clean-frame status; oSLIP slip pulse;
//           oSLIP_CNT saturating slip count.
module synth_slot_sequencer #(
    parameter int VOICES  = 8,
    parameter int V_OSC   = 4,
    parameter int VOICE_W = 3,
    parameter int OSC_W   = 2
) (
    input  logic               OSC_CLK,
    input  logic               iRST_N,
    input  logic               iENABLE,
    input  logic               iSLOT_CLK,
    input  logic               iFRAME_CLK,
    input  logic               iCLR_SLIP,
    output logic [VOICE_W-1:0] oVOICE_IDX,
    output logic [OSC_W-1:0]   oOSC_IDX,
    output logic               oSLOT_STB,
    output logic               oFRAME_STB,
    output logic               oLOCKED,
    output logic               oSLIP,
    output logic [7:0]         oSLIP_CNT
);

    localparam logic [VOICE_W-1:0] LAST_V  = VOICE_W'(VOICES - 1);
    localparam logic [OSC_W-1:0]   LAST_O  = OSC_W'(V_OSC - 1);
    localparam logic [7:0]         CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        RUN        = 2'd1,
        DONE       = 2'd2
    } state_t;

    // Bit 0 is sync flop 1, bit 1 is sync flop 2, and bit 2 is the history
    // flop used for rise detection.
    logic [2:0] slot_sync_q;
    logic [2:0] frame_sync_q;
    logic       slot_tick;
    logic       frame_tick;

    assign slot_tick  = slot_sync_q[1]  & ~slot_sync_q[2];
    assign frame_tick = frame_sync_q[1] & ~frame_sync_q[2];

    state_t             state_q, state_d;
    // The slot counter is held as a (voice, osc) pair, so it maps straight
    // onto the output indices without a divide.
    logic [VOICE_W-1:0] v_cnt_q, v_cnt_d;
    logic [OSC_W-1:0]   o_cnt_q, o_cnt_d;

    logic [VOICE_W-1:0] voice_d;
    logic [OSC_W-1:0]   osc_d;
    logic               slot_stb_d;
    logic               frame_stb_d;
    logic               locked_d;
    logic               slip_d;
    logic [7:0]         slip_cnt_d;

    // These hold the counter value after any frame restart in this cycle. A
    // slot tick that coincides with a frame tick then issues slot 0 of the
    // new frame.
    logic [VOICE_W-1:0] cur_v;
    logic [OSC_W-1:0]   cur_o;
    logic               take_slot;

    always_comb begin
        state_d     = state_q;
        v_cnt_d     = v_cnt_q;
        o_cnt_d     = o_cnt_q;
        voice_d     = oVOICE_IDX;
        osc_d       = oOSC_IDX;
        slot_stb_d  = 1'b0;
        frame_stb_d = 1'b0;
        locked_d    = oLOCKED;
        slip_d      = 1'b0;
        cur_v       = v_cnt_q;
        cur_o       = o_cnt_q;
        take_slot   = 1'b0;

        if (!iENABLE) begin
            state_d  = WAIT_FRAME;
            v_cnt_d  = '0;
            o_cnt_d  = '0;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                WAIT_FRAME: begin
                    // Slot ticks are meaningless until a frame boundary is seen.
                    if (frame_tick) begin
                        frame_stb_d = 1'b1;
                        cur_v       = '0;
                        cur_o       = '0;
                        state_d     = RUN;
                        take_slot   = slot_tick;
                    end
                end
                RUN: begin
                    if (frame_tick) begin
                        // The frame ended before all slots were issued.
                        slip_d      = 1'b1;
                        locked_d    = 1'b0;
                        frame_stb_d = 1'b1;
                        cur_v       = '0;
                        cur_o       = '0;
                        take_slot   = slot_tick;
                    end else begin
                        take_slot   = slot_tick;
                    end
                end
                DONE: begin
                    if (frame_tick) begin
                        frame_stb_d = 1'b1;
                        locked_d    = 1'b1;
                        cur_v       = '0;
                        cur_o       = '0;
                        state_d     = RUN;
                        take_slot   = slot_tick;
                    end else if (slot_tick) begin
                        // This slot tick is beyond the last slot of the frame.
                        slip_d      = 1'b1;
                        locked_d    = 1'b0;
                    end
                end
                default: begin
                    state_d = WAIT_FRAME;
                end
            endcase

            v_cnt_d = cur_v;
            o_cnt_d = cur_o;

            if (take_slot) begin
                slot_stb_d = 1'b1;
                voice_d    = cur_v;
                osc_d      = cur_o;
                if (cur_v == LAST_V && cur_o == LAST_O) begin
                    state_d = DONE;
                    v_cnt_d = '0;
                    o_cnt_d = '0;
                end else if (cur_o == LAST_O) begin
                    state_d = RUN;
                    o_cnt_d = '0;
                    v_cnt_d = cur_v + VOICE_W'(1);
                end else begin
                    state_d = RUN;
                    o_cnt_d = cur_o + OSC_W'(1);
                end
            end
        end
    end

    // The slip counter ignores iENABLE. A clear beats a same-cycle increment.
    always_comb begin
        slip_cnt_d = oSLIP_CNT;
        if (iCLR_SLIP) begin
            slip_cnt_d = '0;
        end else if (slip_d && oSLIP_CNT != CNT_MAX) begin
            slip_cnt_d = oSLIP_CNT + 8'd1;
        end
    end

    always_ff @(posedge OSC_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            slot_sync_q  <= '0;
            frame_sync_q <= '0;
            state_q      <= WAIT_FRAME;
            v_cnt_q      <= '0;
            o_cnt_q      <= '0;
            oVOICE_IDX   <= '0;
            oOSC_IDX     <= '0;
            oSLOT_STB    <= 1'b0;
            oFRAME_STB   <= 1'b0;
            oLOCKED      <= 1'b0;
            oSLIP        <= 1'b0;
            oSLIP_CNT    <= '0;
        end else begin
            slot_sync_q  <= {slot_sync_q[1:0], iSLOT_CLK};
            frame_sync_q <= {frame_sync_q[1:0], iFRAME_CLK};
            state_q      <= state_d;
            v_cnt_q      <= v_cnt_d;
            o_cnt_q      <= o_cnt_d;
            oVOICE_IDX   <= voice_d;
            oOSC_IDX     <= osc_d;
            oSLOT_STB    <= slot_stb_d;
            oFRAME_STB   <= frame_stb_d;
            oLOCKED      <= locked_d;
            oSLIP        <= slip_d;
            oSLIP_CNT    <= slip_cnt_d;
        end
    end

endmodule

// File: tb/tb_synth_slot_sequencer.sv
// Purpose : directed bench for synth_slot_sequencer. It covers the nominal
//           frame, underrun, overrun, coincident ticks, slip-counter
//           saturation and clear, enable drop and async reset.
// Latency : checks the 3-edge input-to-strobe latency at the exact edges.
// Backpressure: none; the stimulus is a linear list of directed steps.
module tb_synth_slot_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       slot_clk;
    logic       frame_clk;
    logic       clr_slip;
    logic [2:0] voice_idx;
    logic [1:0] osc_idx;
    logic       slot_stb;
    logic       frame_stb;
    logic       locked;
    logic       slip;
    logic [7:0] slip_cnt;

    synth_slot_sequencer #(
        .VOICES(8), .V_OSC(4), .VOICE_W(3), .OSC_W(2)
    ) dut (
        .OSC_CLK    (clk),
        .iRST_N     (rst_n),
        .iENABLE    (enable),
        .iSLOT_CLK  (slot_clk),
        .iFRAME_CLK (frame_clk),
        .iCLR_SLIP  (clr_slip),
        .oVOICE_IDX (voice_idx),
        .oOSC_IDX   (osc_idx),
        .oSLOT_STB  (slot_stb),
        .oFRAME_STB (frame_stb),
        .oLOCKED    (locked),
        .oSLIP      (slip),
        .oSLIP_CNT  (slip_cnt)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // The event monitor samples on the falling edge, away from the active edge.
    logic [4:0] strobes[$];
    int         n_frame = 0;
    int         n_slip  = 0;
    int         n_coinc = 0;

    always @(negedge clk) begin
        if (slot_stb)              strobes.push_back({voice_idx, osc_idx});
        if (frame_stb)             n_frame = n_frame + 1;
        if (slip)                  n_slip  = n_slip + 1;
        if (slot_stb && frame_stb) n_coinc = n_coinc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic slots(input int n);
        for (int i = 0; i < n; i++) begin
            slot_clk = 1'b1;
            step(8);
            slot_clk = 1'b0;
            step(8);
        end
    endtask

    task automatic frame_pulse(input int hi, input int lo);
        frame_clk = 1'b1;
        step(hi);
        frame_clk = 1'b0;
        step(lo);
    endtask

    function automatic logic [31:0] last_strobe();
        if (strobes.size() == 0) return 32'hFFFF;
        return {27'd0, strobes[strobes.size() - 1]};
    endfunction

    int frames_before;

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        slot_clk  = 1'b0;
        frame_clk = 1'b0;
        clr_slip  = 1'b0;
        step(3);

        // Reset values
        chk("rst_voice",    {29'd0, voice_idx}, 0);
        chk("rst_osc",      {30'd0, osc_idx},   0);
        chk("rst_slot_stb", {31'd0, slot_stb},  0);
        chk("rst_frm_stb",  {31'd0, frame_stb}, 0);
        chk("rst_locked",   {31'd0, locked},    0);
        chk("rst_slip",     {31'd0, slip},      0);
        chk("rst_slip_cnt", {24'd0, slip_cnt},  0);

        rst_n  = 1'b1;
        enable = 1'b1;
        step(2);

        // Slot ticks before the first frame are ignored without a slip.
        slots(2);
        chk("wait_no_strobe", strobes.size(), 0);
        chk("wait_no_slip",   n_slip, 0);

        // Nominal frame
        frame_pulse(8, 8);
        chk("nom_frame1", n_frame, 1);
        chk("nom_unlocked_first", {31'd0, locked}, 0);
        slots(32);
        chk("nom_count", strobes.size(), 32);
        for (int i = 0; i < 32; i++) begin
            logic [4:0] got;
            logic [4:0] exp_idx;
            got     = (i < strobes.size()) ? strobes[i] : 5'h1F;
            exp_idx = {3'(i / 4), 2'(i % 4)};
            chk($sformatf("nom_idx%0d", i), {27'd0, got}, {27'd0, exp_idx});
        end
        chk("nom_hold_voice", {29'd0, voice_idx}, 7);
        chk("nom_hold_osc",   {30'd0, osc_idx},   3);
        frame_pulse(8, 8);
        chk("nom_frame2", n_frame, 2);
        chk("nom_locked", {31'd0, locked}, 1);
        chk("nom_no_slip", n_slip, 0);

        // Underrun: the frame rise comes after only 20 slots.
        slots(20);
        frame_pulse(8, 8);
        chk("under_slip",   n_slip, 1);
        chk("under_cnt",    {24'd0, slip_cnt}, 1);
        chk("under_locked", {31'd0, locked}, 0);
        slots(1);
        chk("under_next_idx", last_strobe(), 0);
        slots(31);
        frame_pulse(8, 8);
        chk("under_relock", {31'd0, locked}, 1);

        // Overrun: 33 slot rises in one frame.
        strobes.delete();
        slots(33);
        chk("over_strobes", strobes.size(), 32);
        chk("over_slip",    n_slip, 2);
        chk("over_cnt",     {24'd0, slip_cnt}, 2);
        chk("over_locked",  {31'd0, locked}, 0);
        frame_pulse(8, 8);
        chk("over_relock",  {31'd0, locked}, 1);

        // Coincident frame and slot rises from DONE, with exact latency
        slots(32);
        frames_before = n_frame;
        frame_clk = 1'b1;
        slot_clk  = 1'b1;
        step(2);
        chk("coin_lat_slot",  {31'd0, slot_stb},  0);
        chk("coin_lat_frame", {31'd0, frame_stb}, 0);
        step(1);
        chk("coin_slot_stb",  {31'd0, slot_stb},  1);
        chk("coin_frame_stb", {31'd0, frame_stb}, 1);
        chk("coin_voice",     {29'd0, voice_idx}, 0);
        chk("coin_osc",       {30'd0, osc_idx},   0);
        chk("coin_locked",    {31'd0, locked},    1);
        step(5);
        frame_clk = 1'b0;
        slot_clk  = 1'b0;
        step(8);
        chk("coin_once", n_coinc, 1);
        slots(1);
        chk("coin_next_idx", last_strobe(), 1);

        // Saturation: 2 + 300 slips must stick at 255.
        for (int i = 0; i < 300; i++) frame_pulse(3, 3);
        chk("sat_cnt",    {24'd0, slip_cnt}, 255);
        chk("sat_locked", {31'd0, locked}, 0);

        // Clear on the same edge as a slip; the clear wins.
        frame_clk = 1'b1;
        step(2);
        chk("clr_pre_slip", {31'd0, slip}, 0);
        clr_slip = 1'b1;
        step(1);
        clr_slip = 1'b0;
        chk("clr_slip_pulse", {31'd0, slip}, 1);
        chk("clr_cnt_zero",   {24'd0, slip_cnt}, 0);
        step(2);
        frame_clk = 1'b0;
        step(3);
        frame_pulse(3, 3);
        chk("post_clr_cnt", {24'd0, slip_cnt}, 1);

        // Lock, then drop enable at slot 10.
        slots(32);
        frame_pulse(8, 8);
        chk("en_pre_locked", {31'd0, locked}, 1);
        strobes.delete();
        slots(10);
        enable = 1'b0;
        step(1);
        chk("en_locked_clr", {31'd0, locked}, 0);
        chk("en_hold_voice", {29'd0, voice_idx}, 2);
        chk("en_hold_osc",   {30'd0, osc_idx},   1);
        slots(2);
        chk("en_off_no_stb", strobes.size(), 10);
        enable = 1'b1;
        slots(2);
        chk("en_wait_no_stb", strobes.size(), 10);
        frames_before = n_frame;
        enable    = 1'b0;
        frame_clk = 1'b1;
        step(8);
        enable = 1'b1;
        step(8);
        chk("en_high_frame_no_tick", n_frame, frames_before);
        frame_clk = 1'b0;
        step(4);
        slots(1);
        chk("en_still_wait", strobes.size(), 10);
        frame_pulse(8, 8);
        chk("en_new_frame", n_frame, frames_before + 1);
        slots(1);
        chk("en_restart_idx", last_strobe(), 0);

        // Async reset mid-frame
        slots(4);
        chk("rstm_pre_voice", {29'd0, voice_idx}, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstm_voice",    {29'd0, voice_idx}, 0);
        chk("rstm_osc",      {30'd0, osc_idx},   0);
        chk("rstm_slot_stb", {31'd0, slot_stb},  0);
        chk("rstm_locked",   {31'd0, locked},    0);
        chk("rstm_slip_cnt", {24'd0, slip_cnt},  0);
        #2;
        rst_n = 1'b1;
        step(2);
        strobes.delete();
        slots(2);
        chk("rstm_wait_no_stb", strobes.size(), 0);
        frame_pulse(8, 8);
        slots(1);
        chk("rstm_restart_idx", last_strobe(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/synth_slot_sequencer.md
Name: synth_slot_sequencer

Overview:
- Sequences the voice/oscillator time-multiplexed datapath from the synth clock divider outputs.
- Runs in the OSC_CLK domain and samples the divided slot clock (sCLK_XVXOSC) and sample-frame clock (LRCK_1X).
- Emits one strobe per voice×osc slot with the slot's indices, plus a frame-start strobe.
- Detects and reports frame/slot misalignment (slips) and resynchronises automatically.

Parameters:
- VOICES, 8, voices per sample frame.
- V_OSC, 4, oscillators per voice; slots per frame N = VOICES*V_OSC.
- VOICE_W, 3, width of voice index; must be >= clog2(VOICES).
- OSC_W, 2, width of osc index; must be >= clog2(V_OSC).

Ports:
- OSC_CLK  input  1  system clock; all logic on its rising edge.
- iRST_N  input  1  reset, asynchronous assert, active-low.
- iENABLE  input  1  sequencer enable, synchronous to OSC_CLK.
- iSLOT_CLK  input  1  slot clock (sCLK_XVXOSC); treated as asynchronous level.
- iFRAME_CLK  input  1  frame clock (LRCK_1X); treated as asynchronous level.
- iCLR_SLIP  input  1  synchronous clear of oSLIP_CNT.
- oVOICE_IDX  output  VOICE_W  voice index of the current slot.
- oOSC_IDX  output  OSC_W  oscillator index of the current slot.
- oSLOT_STB  output  1  one-cycle slot-valid pulse.
- oFRAME_STB  output  1  one-cycle frame-start pulse.
- oLOCKED  output  1  high after a complete, clean frame.
- oSLIP  output  1  one-cycle misalignment pulse.
- oSLIP_CNT  output  8  saturating slip counter.

Behaviour:
- Reset (iRST_N low, async): all outputs 0, slot counter 0, state WAIT_FRAME, synchroniser flops 0.
- Input conditioning:
  - Each of iSLOT_CLK and iFRAME_CLK passes through a 2-flop synchroniser plus a history flop.
  - slot_tick / frame_tick = synced value high and history value low.
  - All outputs are registered. Fixed latency is 3 OSC_CLK edges from a rise captured at sync flop 1 to the corresponding strobe high.
- Slot mapping: slot s in 0..N-1 gives oOSC_IDX = s mod V_OSC and oVOICE_IDX = s / V_OSC (osc varies fastest).
- oVOICE_IDX and oOSC_IDX update only with oSLOT_STB and hold between strobes.
- WAIT_FRAME:
  - slot_tick is ignored (no slip).
  - frame_tick: pulse oFRAME_STB, set slot counter to 0, go to RUN.
- RUN, slot_tick only:
  - Pulse oSLOT_STB with the indices for the current slot counter, then increment the counter.
  - After issuing slot N-1, go to DONE.
- RUN, frame_tick (underrun, frame ended with fewer than N slots):
  - Pulse oSLIP, clear oLOCKED, increment oSLIP_CNT.
  - Pulse oFRAME_STB and restart RUN at slot 0.
- DONE, frame_tick: pulse oFRAME_STB, set oLOCKED=1, go to RUN at slot 0.
- DONE, slot_tick (overrun): pulse oSLIP, clear oLOCKED, increment oSLIP_CNT, issue no oSLOT_STB, stay in DONE.
- Simultaneous frame_tick and slot_tick in the same cycle:
  - frame_tick is handled first, using the rules for the current state (slip or lock decision included).
  - The slot_tick is then issued as slot 0 of the new frame: oFRAME_STB and oSLOT_STB (indices 0,0) are high together, and the counter becomes 1.
  - If N=1, the next state is DONE.
- oSLIP_CNT:
  - Saturates at 255.
  - iCLR_SLIP clears it to 0 and takes priority over an increment in the same cycle.
  - Not affected by iENABLE.
- iENABLE low:
  - Next edge forces WAIT_FRAME, counter 0, all strobes 0, oLOCKED 0. Indices hold their last values.
  - Synchronisers keep running, so a frame already high when enable returns produces no tick until its next rise.
- Reset asserted mid-frame returns immediately to reset values. After release, the first action is waiting for a frame rise.

Test Plan:
- Nominal: VOICES=8, V_OSC=4; frame rise, then 32 slot rises (slot period 16 cycles), then a frame rise -> 32 oSLOT_STB with (voice,osc) sequence (0,0),(0,1)..(7,3); oLOCKED=1 at second oFRAME_STB; oSLIP never high.
- Underrun: frame rise after only 20 slots -> oSLIP pulse, oSLIP_CNT=1, oLOCKED=0, next strobe indices (0,0); next clean frame restores oLOCKED=1.
- Overrun: 33 slot rises in one frame -> 32 strobes, 33rd produces oSLIP and no strobe, oSLIP_CNT increments; next frame rise leaves oLOCKED=1 (frame was complete).
- Coincident ticks: frame and slot inputs rising on the same OSC_CLK edge from DONE -> oFRAME_STB and oSLOT_STB high in the same cycle, indices (0,0), oLOCKED=1; next slot gives (0,1).
- Saturation and clear: force 300 underruns -> oSLIP_CNT=255; assert iCLR_SLIP together with a slip -> oSLIP_CNT=0.
- Enable/reset mid-frame: drop iENABLE at slot 10 -> oLOCKED=0, no strobes until a new frame rise after re-enable; async iRST_N pulse mid-frame -> all outputs 0 in the same cycle, without waiting for a clock edge.
